bht_update_ctrl: RTL and testbench
==================================

Name: bht_update_ctrl

Overview:
- Write-side companion to the 2-bit branch history tables.
- Captures each lookup (index, 2-bit counter state read, history bit used to select the table) into an in-flight FIFO at fetch.
- At branch resolution, pairs the oldest entry with the actual outcome, computes the next saturating-counter state, and issues exactly one single-cycle write to the table that supplied the prediction.
- Also maintains the global 1-bit history, a misprediction pulse and statistics counters.

Parameters:
- IDX_W, 10, width of the table index.
- DEPTH, 4, in-flight branch entries; power of 2, at least 2.
- CNT_W, 16, width of the branch and misprediction counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all in-flight entries.
- pred_valid  input  1  lookup record offered.
- pred_ready  output  1  FIFO can accept a lookup record.
- pred_idx  input  IDX_W  table index of the lookup.
- pred_state  input  2  counter state returned by the table.
- pred_hist  input  1  history bit used for the lookup; 1 selects table 1, 0 selects table 2.
- res_valid  input  1  resolution offered.
- res_ready  output  1  a resolution can be accepted.
- res_taken  input  1  actual outcome; 1 = taken.
- wr_en1  output  1  write strobe to table 1.
- wr_en2  output  1  write strobe to table 2.
- wr_idx  output  IDX_W  write index.
- wr_data  output  2  next counter state.
- mispredict  output  1  one-cycle pulse on a wrong prediction.
- hist_out  output  1  global history (last resolved outcome); drives table select for new lookups.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.
- branch_cnt  output  CNT_W  resolved branches, saturating.
- mispred_cnt  output  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0. The following outputs are 0: occupancy, wr_en1, wr_en2, wr_idx, wr_data, mispredict, hist_out, both counters. pred_ready=1, res_ready=0. A write pending at reset is dropped.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 11 strong-T, 10 weak-T.
  - Predicted taken = state[1].
- Next state (current state, taken / not-taken):
  - 00: T→01, NT→00.
  - 01: T→11, NT→00.
  - 11: T→11, NT→10.
  - 10: T→11, NT→00.
- Push: occurs when pred_valid & pred_ready. pred_ready = (occupancy != DEPTH). The entry stores {pred_idx, pred_state, pred_hist}.
- Pop: occurs when res_valid & res_ready. res_ready = (occupancy != 0). There is no same-cycle bypass: a record pushed in cycle N can be resolved in cycle N+1 at the earliest.
- Simultaneous push and pop when 0 < occupancy < DEPTH: both happen and occupancy is unchanged.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - When empty, a pop is refused even if a push occurs in the same cycle.
- Write latency: 1 cycle. The cycle after a pop, the following are registered:
  - wr_en1 = head.hist and wr_en2 = ~head.hist (exactly one high).
  - wr_idx = head.idx, wr_data = next(head.state, res_taken).
  - mispredict = (head.state[1] != res_taken).
  - All strobes are 0 in cycles without a pop. wr_idx and wr_data hold their last value.
- hist_out is updated to res_taken on the same edge as the write. The history bit of the most recent push is not used.
- branch_cnt increments by 1 per pop. mispred_cnt increments by 1 per misprediction. Both saturate at all-ones.
- Pointers wrap modulo DEPTH.
- Flush:
  - Empties the FIFO on the next edge. It has priority over push and pop that cycle: a pop in a flush cycle produces no write and no counter update.
  - Does not change hist_out, the counters, or a write already registered.
  - pred_ready and res_ready are not gated by flush.
- Consecutive pops to the same index are not merged. Each write uses the state captured at lookup; staleness is accepted by design.

Test Plan:
- Reset, then push {idx=0x0F0, state=00, hist=1}, then resolve taken → one cycle later: wr_en1=1, wr_en2=0, wr_idx=0x0F0, wr_data=01, mispredict=1, hist_out=1, branch_cnt=1, mispred_cnt=1.
- Push 4 entries with states 00, 01, 11, 10 and hist=0; resolve them as NT, T, NT, T → wr_en2 pulses with wr_data 00, 11, 10, 11; mispredict sequence 0, 1, 1, 0; mispred_cnt=2.
- Fill to DEPTH=4 → pred_ready=0. Hold pred_valid and pop once → the 5th push is refused that cycle and accepted the next cycle; occupancy sequence 4, 3, 4.
- With occupancy=0, assert res_valid and pred_valid together → no write, occupancy=1. Resolve in the next cycle → write is issued.
- With 3 in flight, assert flush together with res_valid=1 → occupancy=0 next cycle, no strobe, counters and hist_out unchanged, res_ready=0.
- Assert rst_n=0 mid-stream, in the cycle after a pop → wr_en1 and wr_en2 forced to 0 immediately, occupancy=0, pred_ready=1, counters 0.

Source files
------------

// File: rtl/bht_update_ctrl_if.sv
// Lookup/resolution handshakes and table-write bus of the BHT update controller.
// The master drives lookups, resolutions and flush; the slave returns writes and status.
interface bht_update_ctrl_if #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       pred_state;
    logic             pred_hist;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic             wr_en1;
    logic             wr_en2;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_data;
    logic             mispredict;
    logic             hist_out;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output flush, pred_valid, pred_idx, pred_state, pred_hist, res_valid, res_taken,
        input  pred_ready, res_ready, wr_en1, wr_en2, wr_idx, wr_data, mispredict,
               hist_out, occupancy, branch_cnt, mispred_cnt
    );

    modport slave (
        input  flush, pred_valid, pred_idx, pred_state, pred_hist, res_valid, res_taken,
        output pred_ready, res_ready, wr_en1, wr_en2, wr_idx, wr_data, mispredict,
               hist_out, occupancy, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// Write-side controller for the two 2-bit branch history tables: queues lookups,
// pairs them with resolutions in order and issues one registered counter update each.
module bht_update_ctrl #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    bht_update_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       state;
        logic             hist;
    } entry_t;

    entry_t           fifo [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic             wr_en1_q;
    logic             wr_en2_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [1:0]       wr_data_q;
    logic             mispredict_q;
    logic             hist_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic   can_push;
    logic   can_pop;
    logic   push;
    logic   pop;
    logic   miss;
    entry_t head;

    // Encoding 00 sNT, 01 wNT, 11 sT, 10 wT; bit 1 is the prediction.
    function automatic logic [1:0] next_state(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = 2'b00;
        unique case (cur)
            2'b00: nxt = taken ? 2'b01 : 2'b00;
            2'b01: nxt = taken ? 2'b11 : 2'b00;
            2'b11: nxt = taken ? 2'b11 : 2'b10;
            2'b10: nxt = taken ? 2'b11 : 2'b00;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Readiness comes from occupancy alone, so flush never gates the handshake.
    assign can_push = (occ != OCC_W'(DEPTH));
    assign can_pop  = (occ != '0);
    assign push     = bus.pred_valid & can_push & ~bus.flush;
    assign pop      = bus.res_valid & can_pop & ~bus.flush;
    assign head     = fifo[rd_ptr];
    assign miss     = (head.state[1] != bus.res_taken);

    assign bus.pred_ready  = can_push;
    assign bus.res_ready   = can_pop;
    assign bus.occupancy   = occ;
    assign bus.wr_en1      = wr_en1_q;
    assign bus.wr_en2      = wr_en2_q;
    assign bus.wr_idx      = wr_idx_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.hist_out    = hist_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{idx: bus.pred_idx, state: bus.pred_state, hist: bus.pred_hist};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (pop && !push) occ <= occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en1_q      <= 1'b0;
            wr_en2_q      <= 1'b0;
            wr_idx_q      <= '0;
            wr_data_q     <= 2'b00;
            mispredict_q  <= 1'b0;
            hist_q        <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            wr_en1_q     <= pop & head.hist;
            wr_en2_q     <= pop & ~head.hist;
            mispredict_q <= pop & miss;
            if (pop) begin
                wr_idx_q  <= head.idx;
                wr_data_q <= next_state(head.state, bus.res_taken);
                hist_q    <= bus.res_taken;
                if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                if (miss && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_bht_update_ctrl;
    localparam int IDX_W = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        int idx;
        int state;
        int hist;
    } rec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    bht_update_ctrl_if #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    bht_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of lookups plus the transition table written out as data.
    rec_t q[$];
    int   nxt_t [4] = '{1, 3, 3, 3};
    int   nxt_nt[4] = '{0, 0, 0, 2};
    int   m_en1, m_en2, m_idx, m_data, m_misp, m_hist, m_bcnt, m_mcnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_en1 = 0; m_en2 = 0; m_idx = 0; m_data = 0; m_misp = 0;
            m_hist = 0; m_bcnt = 0; m_mcnt = 0;
        end else begin
            bit do_push, do_pop;
            do_push = bus.pred_valid && q.size() < DEPTH;
            do_pop  = bus.res_valid && q.size() > 0;
            m_en1 = 0; m_en2 = 0; m_misp = 0;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    rec_t e;
                    int   tk;
                    e  = q.pop_front();
                    tk = int'(bus.res_taken);
                    m_en1  = e.hist;
                    m_en2  = 1 - e.hist;
                    m_idx  = e.idx;
                    m_data = tk ? nxt_t[e.state] : nxt_nt[e.state];
                    m_misp = ((e.state >= 2) != (tk == 1)) ? 1 : 0;
                    m_hist = tk;
                    if (m_bcnt < CMAX) m_bcnt++;
                    if (m_misp == 1 && m_mcnt < CMAX) m_mcnt++;
                end
                if (do_push) q.push_back('{int'(bus.pred_idx), int'(bus.pred_state), int'(bus.pred_hist)});
            end
        end
        #1;
        chk("occupancy",   int'(bus.occupancy), q.size());
        chk("pred_ready",  int'(bus.pred_ready), (q.size() != DEPTH) ? 1 : 0);
        chk("res_ready",   int'(bus.res_ready), (q.size() != 0) ? 1 : 0);
        chk("wr_en1",      int'(bus.wr_en1), m_en1);
        chk("wr_en2",      int'(bus.wr_en2), m_en2);
        chk("wr_idx",      int'(bus.wr_idx), m_idx);
        chk("wr_data",     int'(bus.wr_data), m_data);
        chk("mispredict",  int'(bus.mispredict), m_misp);
        chk("hist_out",    int'(bus.hist_out), m_hist);
        chk("branch_cnt",  int'(bus.branch_cnt), m_bcnt);
        chk("mispred_cnt", int'(bus.mispred_cnt), m_mcnt);
    end

    // Drive one cycle of inputs at the falling edge; return just after the next rising edge.
    task automatic step(input bit pv, input int idx, input int st, input bit h,
                        input bit rv, input bit rt, input bit fl);
        @(negedge clk);
        bus.pred_valid = pv;
        bus.pred_idx   = IDX_W'(idx);
        bus.pred_state = 2'(st);
        bus.pred_hist  = h;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        bus.flush      = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int idx, input int st, input bit h);
        step(1, idx, st, h, 0, 0, 0);
    endtask

    task automatic pop(input bit rt);
        step(0, 0, 0, 0, 1, rt, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    int st_seq  [4] = '{0, 1, 3, 2};
    bit tk_seq  [4] = '{0, 1, 0, 1};
    int exp_dat [4] = '{0, 3, 2, 3};
    int exp_misp[4] = '{0, 1, 1, 0};

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.flush = 0; bus.pred_valid = 0; bus.pred_idx = '0; bus.pred_state = '0;
        bus.pred_hist = 0; bus.res_valid = 0; bus.res_taken = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst pred_ready", int'(bus.pred_ready), 1);
        chk("rst res_ready",  int'(bus.res_ready), 0);
        chk("rst occupancy",  int'(bus.occupancy), 0);

        // Single lookup, strong-NT resolved taken.
        push(10'h0F0, 0, 1);
        pop(1);
        chk("t1 wr_en1", int'(bus.wr_en1), 1);
        chk("t1 wr_en2", int'(bus.wr_en2), 0);
        chk("t1 wr_idx", int'(bus.wr_idx), 'h0F0);
        chk("t1 wr_data", int'(bus.wr_data), 1);
        chk("t1 mispredict", int'(bus.mispredict), 1);
        chk("t1 hist_out", int'(bus.hist_out), 1);
        chk("t1 branch_cnt", int'(bus.branch_cnt), 1);
        chk("t1 mispred_cnt", int'(bus.mispred_cnt), 1);
        idle();
        chk("t1 strobe drop", int'(bus.wr_en1), 0);
        chk("t1 idx hold", int'(bus.wr_idx), 'h0F0);

        // All four states through table 2.
        for (int i = 0; i < 4; i++) push(16 + i, st_seq[i], 0);
        chk("t2 full", int'(bus.pred_ready), 0);
        for (int i = 0; i < 4; i++) begin
            pop(tk_seq[i]);
            chk("t2 wr_en2", int'(bus.wr_en2), 1);
            chk("t2 wr_data", int'(bus.wr_data), exp_dat[i]);
            chk("t2 mispredict", int'(bus.mispredict), exp_misp[i]);
        end
        chk("t2 mispred_cnt", int'(bus.mispred_cnt), 3);
        chk("t2 branch_cnt", int'(bus.branch_cnt), 5);

        // Push refused while full even with a concurrent pop.
        for (int i = 0; i < 4; i++) push(32 + i, 3, 1);
        chk("t3 occ full", int'(bus.occupancy), 4);
        step(1, 36, 3, 1, 1, 1, 0);
        chk("t3 occ after pop", int'(bus.occupancy), 3);
        step(1, 36, 3, 1, 0, 0, 0);
        chk("t3 occ refill", int'(bus.occupancy), 4);
        for (int i = 0; i < 4; i++) pop(1);
        chk("t3 last idx", int'(bus.wr_idx), 36);
        chk("t3 branch_cnt", int'(bus.branch_cnt), 10);

        // Pop refused while empty even with a concurrent push.
        step(1, 48, 1, 0, 1, 0, 0);
        chk("t4 no wr_en1", int'(bus.wr_en1), 0);
        chk("t4 no wr_en2", int'(bus.wr_en2), 0);
        chk("t4 occ", int'(bus.occupancy), 1);
        pop(0);
        chk("t4 wr_en2", int'(bus.wr_en2), 1);
        chk("t4 wr_data", int'(bus.wr_data), 0);
        chk("t4 hist_out", int'(bus.hist_out), 0);

        // Flush wins over a concurrent pop.
        for (int i = 0; i < 3; i++) push(64 + i, 2, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        chk("t5 occ", int'(bus.occupancy), 0);
        chk("t5 wr_en1", int'(bus.wr_en1), 0);
        chk("t5 res_ready", int'(bus.res_ready), 0);
        chk("t5 branch_cnt", int'(bus.branch_cnt), 11);
        chk("t5 mispred_cnt", int'(bus.mispred_cnt), 3);
        chk("t5 hist_out", int'(bus.hist_out), 0);

        // Asynchronous reset drops the write registered by the preceding pop.
        push(80, 0, 1);
        pop(1);
        chk("t6 pre wr_en1", int'(bus.wr_en1), 1);
        rst_n = 1'b0;
        #1;
        chk("t6 wr_en1", int'(bus.wr_en1), 0);
        chk("t6 wr_en2", int'(bus.wr_en2), 0);
        chk("t6 occ", int'(bus.occupancy), 0);
        chk("t6 pred_ready", int'(bus.pred_ready), 1);
        chk("t6 branch_cnt", int'(bus.branch_cnt), 0);
        chk("t6 mispred_cnt", int'(bus.mispred_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Counters saturate; the pointers wrap several times on the way.
        for (int i = 0; i < CMAX + 2; i++) begin
            push(96 + i, 0, i[0]);
            pop(1);
        end
        chk("t7 branch_cnt sat", int'(bus.branch_cnt), CMAX);
        chk("t7 mispred_cnt sat", int'(bus.mispred_cnt), CMAX);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
